ddr_tx_serializer: RTL



---
 rtl/ddr_tx_serializer.sv | 101 ++++++++++
 1 files changed

// File: rtl/ddr_tx_serializer.sv
// ddr_tx_serializer: slices 2*N*DW-bit words into N registered (din1, din2) DDR beat pairs,
// LSB first, for a downstream oddr stage. Streams back-to-back words with no bubble.
module ddr_tx_serializer #(
  parameter int unsigned   DW   = 1,
  parameter int unsigned   N    = 4,
  parameter logic [DW-1:0] IDLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [2*N*DW-1:0] in_data,
  output logic              in_ready,
  output logic [DW-1:0]     out_din1,
  output logic [DW-1:0]     out_din2,
  output logic              out_frame,
  output logic              out_active
);

  localparam int unsigned   WW       = 2 * N * DW;
  localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastBeat = CW'(N - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] hold_q, hold_d;
  logic [DW-1:0] din1_q, din1_d, din2_q, din2_d;
  logic          frame_q, frame_d, active_q, active_d;
  logic          accept;

  // Ready depends on state only; the last beat may take the next word so streams have no gap.
  assign in_ready = !reset && ((state_q == StIdle) || (cnt_q == LastBeat));
  assign accept   = in_valid && in_ready;

  assign out_din1   = din1_q;
  assign out_din2   = din2_q;
  assign out_frame  = frame_q;
  assign out_active = active_q;

  // Next-state: load beat 0 straight from in_data on acceptance, later beats from the
  // holding register, which shifts down one pair per beat.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    din1_d   = IDLE;
    din2_d   = IDLE;
    frame_d  = 1'b0;
    active_d = 1'b0;
    if (accept) begin
      state_d  = StSend;
      cnt_d    = '0;
      din1_d   = in_data[DW-1:0];
      din2_d   = in_data[2*DW-1:DW];
      hold_d   = in_data >> (2 * DW);
      frame_d  = 1'b1;
      active_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
        end
        StSend: begin
          if (cnt_q == LastBeat) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            din1_d   = hold_q[DW-1:0];
            din2_d   = hold_q[2*DW-1:DW];
            hold_d   = hold_q >> (2 * DW);
            active_d = 1'b1;
          end
        end
      endcase
    end
  end

  // State and output registers; reset discards any in-flight word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hold_q   <= '0;
      din1_q   <= IDLE;
      din2_q   <= IDLE;
      frame_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      din1_q   <= din1_d;
      din2_q   <= din2_d;
      frame_q  <= frame_d;
      active_q <= active_d;
    end
  end

endmodule
